pc_stack_unit: RTL and testbench

- Parametrised program counter for the fetch stage, successor to the basic PC.
- Adds signed relative branches, call/return via an internal hardware return-address stack, and stack status/error flags.
- Drives the instruction-memory address; control inputs come from the decode/control unit.

---
 rtl/pc_stack_unit.sv | 111 +++++++++++
 tb/tb_pc_stack_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with relative branches and a hardware return-address stack.
// Stack status flags decode the registered depth; stack_err latches any overflow/underflow until reset.
module pc_stack_unit #(
    parameter  int D           = 12,
    parameter  int OFFSET_W    = 8,
    parameter  int STACK_DEPTH = 4,
    localparam int SW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nextFlag,
    input  logic                absjump_en,
    input  logic                reljump_en,
    input  logic                call_en,
    input  logic                ret_en,
    input  logic [D-1:0]        target,
    input  logic [OFFSET_W-1:0] offset,
    output logic [D-1:0]        prog_ctr,
    output logic [SW-1:0]       stack_depth,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                stack_err
);

    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SW-1:0] DEPTH_MAX = SW'(STACK_DEPTH);

    logic [D-1:0]  r_pc;
    logic [SW-1:0] r_depth;
    logic          r_err;
    // Sized to a power of two so the index width matches exactly; only STACK_DEPTH entries are used.
    logic [D-1:0]  r_stack [2**IW];

    logic [D-1:0]          w_pc_inc;
    logic [D-1:0]          w_pc_rel;
    logic signed [OFFSET_W-1:0] w_off_s;
    logic [D-1:0]          w_off_ext;
    logic [IW-1:0]         w_top_idx;
    logic [IW-1:0]         w_push_idx;
    logic [D-1:0]          w_top;
    logic                  w_full;
    logic                  w_empty;

    logic [D-1:0]  w_pc_next;
    logic [SW-1:0] w_depth_next;
    logic          w_err_next;
    logic          w_push;

    assign w_full     = (r_depth == DEPTH_MAX);
    assign w_empty    = (r_depth == '0);
    assign w_pc_inc   = r_pc + D'(1);
    assign w_off_s    = offset;
    assign w_off_ext  = D'(w_off_s);
    assign w_pc_rel   = r_pc + w_off_ext;
    assign w_top_idx  = IW'(r_depth - SW'(1));
    assign w_push_idx = IW'(r_depth);
    assign w_top      = r_stack[w_top_idx];

    always_comb begin
        w_pc_next    = w_pc_inc;
        w_depth_next = r_depth;
        w_err_next   = r_err;
        w_push       = 1'b0;
        if (ret_en) begin
            if (!w_empty) begin
                w_pc_next    = w_top;
                w_depth_next = r_depth - SW'(1);
            end else begin
                w_err_next = 1'b1;
            end
        end else if (call_en) begin
            if (!w_full) begin
                w_push       = 1'b1;
                w_pc_next    = target;
                w_depth_next = r_depth + SW'(1);
            end else begin
                w_err_next = 1'b1;
            end
        end else if (absjump_en) begin
            w_pc_next = target;
        end else if (reljump_en) begin
            w_pc_next = w_pc_rel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else if (nextFlag) begin
            r_pc    <= w_pc_next;
            r_depth <= w_depth_next;
            r_err   <= w_err_next;
        end
    end

    // Stack contents need no reset; a push while reset is asserted is blocked so reset truly aborts a call.
    always_ff @(posedge clk) begin
        if (!reset && nextFlag && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign prog_ctr    = r_pc;
    assign stack_depth = r_depth;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign stack_err   = r_err;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: sequencing, jumps, call/return stack, overflow/underflow and async reset.
module tb_pc_stack_unit;

    localparam int D  = 12;
    localparam int OW = 8;
    localparam int SD = 4;
    localparam int SW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          nextFlag;
    logic          absjump_en;
    logic          reljump_en;
    logic          call_en;
    logic          ret_en;
    logic [D-1:0]  target;
    logic [OW-1:0] offset;
    logic [D-1:0]  prog_ctr;
    logic [SW-1:0] stack_depth;
    logic          stack_full;
    logic          stack_empty;
    logic          stack_err;

    int n_checks = 0;
    int n_errors = 0;

    pc_stack_unit #(.D(D), .OFFSET_W(OW), .STACK_DEPTH(SD)) dut (
        .clk         (clk),
        .reset       (reset),
        .nextFlag    (nextFlag),
        .absjump_en  (absjump_en),
        .reljump_en  (reljump_en),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .target      (target),
        .offset      (offset),
        .prog_ctr    (prog_ctr),
        .stack_depth (stack_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic ctl(input logic nf, input logic r, input logic c, input logic a,
                       input logic j, input logic [D-1:0] t, input logic [OW-1:0] o);
        nextFlag   = nf;
        ret_en     = r;
        call_en    = c;
        absjump_en = a;
        reljump_en = j;
        target     = t;
        offset     = o;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_pc(input string tag, input logic [D-1:0] exp_pc);
        step();
        chk(tag, 32'(prog_ctr), 32'(exp_pc));
    endtask

    initial begin
        reset = 1'b1;
        ctl(0, 0, 0, 0, 0, '0, '0);
        #12;
        chk("rst_pc",    32'(prog_ctr), 32'h0);
        chk("rst_depth", 32'(stack_depth), 32'd0);
        chk("rst_empty", 32'(stack_empty), 32'd1);
        chk("rst_full",  32'(stack_full), 32'd0);
        chk("rst_err",   32'(stack_err), 32'd0);
        step();
        reset = 1'b0;

        // Sequential increment, then hold with nextFlag low
        ctl(1, 0, 0, 0, 0, '0, '0);
        step_pc("inc1", 12'h001);
        step_pc("inc2", 12'h002);
        step_pc("inc3", 12'h003);
        ctl(0, 0, 0, 1, 0, 12'h500, '0);
        step_pc("hold1", 12'h003);
        step_pc("hold2", 12'h003);

        // Absolute jump and wrap
        ctl(1, 0, 0, 1, 0, 12'hFFE, '0);
        step_pc("abs_ffe", 12'hFFE);
        ctl(1, 0, 0, 0, 0, '0, '0);
        step_pc("inc_fff", 12'hFFF);
        step_pc("wrap_000", 12'h000);

        // Relative branches
        ctl(1, 0, 0, 1, 0, 12'h010, '0);
        step_pc("abs_010", 12'h010);
        ctl(1, 0, 0, 0, 1, '0, 8'hFE);
        step_pc("rel_neg2", 12'h00E);
        ctl(1, 0, 0, 1, 0, 12'hFF0, '0);
        step_pc("abs_ff0", 12'hFF0);
        ctl(1, 0, 0, 0, 1, '0, 8'h7F);
        step_pc("rel_wrap", 12'h06F);

        // Single call / return
        ctl(1, 0, 0, 1, 0, 12'h020, '0);
        step_pc("abs_020", 12'h020);
        ctl(1, 0, 1, 0, 0, 12'h100, '0);
        step_pc("call_100", 12'h100);
        chk("call_depth", 32'(stack_depth), 32'd1);
        ctl(1, 1, 0, 0, 0, '0, '0);
        step_pc("ret_021", 12'h021);
        chk("ret_depth", 32'(stack_depth), 32'd0);
        chk("ret_empty", 32'(stack_empty), 32'd1);
        chk("ret_err",   32'(stack_err), 32'd0);

        // Nested calls to full
        ctl(1, 0, 1, 0, 0, 12'h200, '0);
        step_pc("call_200", 12'h200);
        ctl(1, 0, 1, 0, 0, 12'h210, '0);
        step_pc("call_210", 12'h210);
        ctl(1, 0, 1, 0, 0, 12'h220, '0);
        step_pc("call_220", 12'h220);
        chk("nfull_3", 32'(stack_full), 32'd0);
        ctl(1, 0, 1, 0, 0, 12'h300, '0);
        step_pc("call_300", 12'h300);
        chk("full_4",  32'(stack_full), 32'd1);
        chk("depth_4", 32'(stack_depth), 32'd4);
        ctl(1, 0, 1, 0, 0, 12'h700, '0);
        step_pc("ovf_pc", 12'h301);
        chk("ovf_depth", 32'(stack_depth), 32'd4);
        chk("ovf_err",   32'(stack_err), 32'd1);

        // Unwind in reverse order
        ctl(1, 1, 0, 0, 0, '0, '0);
        step_pc("ret_221", 12'h221);
        chk("unw_d3", 32'(stack_depth), 32'd3);
        step_pc("ret_211", 12'h211);
        step_pc("ret_201", 12'h201);
        step_pc("ret_022", 12'h022);
        chk("unw_d0", 32'(stack_depth), 32'd0);
        step_pc("unf_pc", 12'h023);
        chk("unf_err",   32'(stack_err), 32'd1);
        chk("unf_depth", 32'(stack_depth), 32'd0);

        // Priority: ret beats call and absjump
        ctl(1, 0, 1, 0, 0, 12'h400, '0);
        step_pc("call_400", 12'h400);
        ctl(1, 1, 1, 1, 0, 12'h555, '0);
        step_pc("prio_ret", 12'h024);
        chk("prio_depth", 32'(stack_depth), 32'd0);

        // Async reset between edges aborts a call in progress
        ctl(1, 0, 1, 0, 0, 12'h123, '0);
        step_pc("call_123", 12'h123);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc",    32'(prog_ctr), 32'h0);
        chk("arst_depth", 32'(stack_depth), 32'd0);
        chk("arst_err",   32'(stack_err), 32'd0);
        step();
        chk("arst_hold_pc", 32'(prog_ctr), 32'h0);
        reset = 1'b0;
        ctl(1, 0, 0, 0, 0, '0, '0);
        step_pc("post_rst", 12'h001);
        chk("post_depth", 32'(stack_depth), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
